// File: rtl/prefix_adder_pipe.sv
// Two-stage pipelined add/sub/accumulate unit: low half in stage 1, high half in stage 2, Kogge-Stone carries per half.
// Latency 2 edges, throughput 1/cycle; holds up to 2 beats under out_ready=0, ACC waits for in-flight ACC/LOAD.
module prefix_adder_pipe #(
  parameter int D_WIDTH = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [D_WIDTH-1:0] A,
  input  logic [D_WIDTH-1:0] B,
  input  logic               Cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] Sout,
  output logic               Cout,
  output logic               Ovf
);

  localparam int H = D_WIDTH / 2;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Returns {carry_out, sum} of x + y + c using a Kogge-Stone prefix tree.
  function automatic logic [H:0] ks_add(input logic [H-1:0] x, input logic [H-1:0] y,
                                        input logic c);
    logic [H-1:0] p, gg, pp, gn, pn, s;
    logic         co;
    p  = x ^ y;
    gg = x & y;
    pp = p;
    for (int d = 1; d < H; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < H; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    s[0] = p[0] ^ c;
    for (int i = 1; i < H; i++) begin
      s[i] = p[i] ^ (gg[i-1] | (pp[i-1] & c));
    end
    co = gg[H-1] | (pp[H-1] & c);
    return {co, s};
  endfunction

  logic [D_WIDTH-1:0] acc;
  logic               s1_vld, s2_vld;
  logic [1:0]         s1_op, s2_op;
  logic [H-1:0]       s1_lo, s1_xhi, s1_yhi;
  logic               s1_c;

  logic [D_WIDTH-1:0] x, y;
  logic               c;
  logic [H:0]         lo_res, hi_res;
  logic               s2_ld, s1_ld, acc_hazard, in_fire, s2_ovf;

  assign out_valid  = s2_vld;
  assign s2_ld      = !s2_vld || out_ready;
  assign s1_ld      = !s1_vld || s2_ld;
  // op[1] set means ACC or LOAD: both produce the next accumulator value
  assign acc_hazard = (in_op == OP_ACC) && ((s1_vld && s1_op[1]) || (s2_vld && s2_op[1]));
  assign in_ready   = !rst && s1_ld && !acc_hazard;
  assign in_fire    = in_valid && in_ready;

  always_comb begin
    x = A;
    y = B;
    c = Cin;
    case (in_op)
      OP_ADD:  begin x = A;   y = B;                 c = Cin;  end
      OP_SUB:  begin x = A;   y = ~B;                c = 1'b1; end
      OP_ACC:  begin x = acc; y = A;                 c = Cin;  end
      OP_LOAD: begin x = A;   y = '0;                c = 1'b0; end
      default: begin x = A;   y = B;                 c = Cin;  end
    endcase
  end

  assign lo_res = ks_add(x[H-1:0], y[H-1:0], c);
  assign hi_res = ks_add(s1_xhi, s1_yhi, s1_c);
  assign s2_ovf = (s1_op != OP_LOAD) && (s1_xhi[H-1] == s1_yhi[H-1]) &&
                  (hi_res[H-1] != s1_xhi[H-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_op  <= OP_ADD;
      s2_op  <= OP_ADD;
      s1_lo  <= '0;
      s1_c   <= 1'b0;
      s1_xhi <= '0;
      s1_yhi <= '0;
      Sout   <= '0;
      Cout   <= 1'b0;
      Ovf    <= 1'b0;
      acc    <= '0;
    end else begin
      if (out_valid && out_ready && s2_op[1]) begin
        acc <= Sout;
      end
      if (s2_ld) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          Sout  <= {hi_res[H-1:0], s1_lo};
          Cout  <= hi_res[H];
          Ovf   <= s2_ovf;
          s2_op <= s1_op;
        end
      end
      if (s1_ld) begin
        s1_vld <= in_fire;
        if (in_fire) begin
          s1_op  <= in_op;
          s1_lo  <= lo_res[H-1:0];
          s1_c   <= lo_res[H];
          s1_xhi <= x[D_WIDTH-1:H];
          s1_yhi <= y[D_WIDTH-1:H];
        end
      end
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Randomized and directed bench for prefix_adder_pipe against an arithmetic reference model.
module tb_prefix_adder_pipe;
  localparam int D = 40;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, Cin, out_valid, out_ready, Cout, Ovf;
  logic [1:0]   in_op;
  logic [D-1:0] A, B, Sout;

  prefix_adder_pipe #(.D_WIDTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
    .Sout(Sout), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [D-1:0] s;
    logic         co;
    logic         ov;
    logic         isacc;
    int           t;
  } exp_t;

  exp_t         q[$];
  logic [D-1:0] macc;
  int           nacc, cyc, n_chk, n_err, acc_stalls, n_in;
  logic         last_acc;
  logic [D-1:0] last_sout;
  logic         last_cout, last_ovf;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [D-1:0] a, b, input logic ci);
    exp_t         e;
    logic [D-1:0] xx, yy;
    logic         cc;
    logic [D:0]   sum;
    xx = a; yy = b; cc = ci;
    if (op == SUB) begin yy = ~b; cc = 1'b1; end
    if (op == ACC) begin xx = macc; yy = a; end
    sum     = {1'b0, xx} + {1'b0, yy} + {{D{1'b0}}, cc};
    e.s     = sum[D-1:0];
    e.co    = sum[D];
    e.ov    = (xx[D-1] == yy[D-1]) && (e.s[D-1] != xx[D-1]);
    e.isacc = op[1];
    if (op == LOAD) begin e.s = a; e.co = 1'b0; e.ov = 1'b0; end
    e.t = cyc;
    return e;
  endfunction

  // One clock cycle: drive, check against the model, clock, update the model.
  task automatic step(input logic v, input logic [1:0] op, input logic [D-1:0] a, b,
                      input logic ci, input logic ordy, input logic r);
    logic exp_rdy, exp_ov, fire_in, fire_out;
    exp_t e;
    rst = r; in_valid = v; in_op = op; A = a; B = b; Cin = ci; out_ready = ordy;
    #1;
    exp_rdy = !r && (q.size() < 2 || ordy) && !(op == ACC && nacc > 0);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    exp_ov = (q.size() > 0) && (q[0].t + 1 < cyc);
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
    if (out_valid && exp_ov) begin
      chk("sout", {24'd0, Sout}, {24'd0, q[0].s});
      chk("cout", {63'd0, Cout}, {63'd0, q[0].co});
      chk("ovf",  {63'd0, Ovf},  {63'd0, q[0].ov});
    end
    if (v && op == ACC && !in_ready && !r) acc_stalls++;
    fire_in  = v && in_ready;
    fire_out = out_valid && ordy;
    @(posedge clk);
    last_acc = 1'b0;
    if (r) begin
      q.delete(); macc = '0; nacc = 0;
    end else begin
      if (fire_out) begin
        last_sout = Sout; last_cout = Cout; last_ovf = Ovf;
        if (q.size() > 0) begin
          if (q[0].isacc) nacc--;
          void'(q.pop_front());
        end
      end
      if (fire_in) begin
        e = model(op, a, b, ci);
        if (op[1]) begin macc = e.s; nacc++; end
        q.push_back(e);
        last_acc = 1'b1;
        n_in++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [D-1:0] a, b, input logic ci,
                      input logic ordy);
    int k;
    k = 0;
    do begin
      step(1'b1, op, a, b, ci, ordy, 1'b0);
      k++;
    end while (!last_acc && k < 30);
    if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 30) begin
      step(1'b0, ADD, '0, '0, 1'b0, 1'b1, 1'b0);
      k++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [D-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: t = '1;
      1: t = 64'h0;
      2: t = 64'h7F_FFFF_FFFF;
      3: t = 64'h80_0000_0000;
      default: ;
    endcase
    return t[D-1:0];
  endfunction

  initial begin
    logic [D-1:0] va[4];
    int           acc_cnt;
    n_chk = 0; n_err = 0; cyc = 0; nacc = 0; macc = '0; acc_stalls = 0; n_in = 0;
    last_sout = '0; last_cout = 1'b0; last_ovf = 1'b0; last_acc = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_op = ADD; A = '0; B = '0; Cin = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    step(1'b0, ADD, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("reset_sout", {24'd0, Sout}, 64'd0);
    chk("reset_cout_ovf", {62'd0, Cout, Ovf}, 64'd0);

    // Carry across all bits and latency
    send(ADD, 40'hFF_FFFF_FFFF, 40'd1, 1'b0, 1'b1);
    step(1'b0, ADD, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("lat_valid_n2", {63'd0, out_valid}, 64'd1);
    drain();
    chk("add_wrap_sout", {24'd0, last_sout}, 64'd0);
    chk("add_wrap_cout", {63'd0, last_cout}, 64'd1);
    chk("add_wrap_ovf",  {63'd0, last_ovf},  64'd0);

    send(SUB, 40'd5, 40'd7, 1'b0, 1'b1);
    drain();
    chk("sub_sout", {24'd0, last_sout}, 64'hFF_FFFF_FFFE);
    chk("sub_cout", {63'd0, last_cout}, 64'd0);
    chk("sub_ovf",  {63'd0, last_ovf},  64'd0);
    send(ADD, 40'h7F_FFFF_FFFF, 40'd1, 1'b0, 1'b1);
    drain();
    chk("ovf_sout", {24'd0, last_sout}, 64'h80_0000_0000);
    chk("ovf_ovf",  {63'd0, last_ovf},  64'd1);
    chk("ovf_cout", {63'd0, last_cout}, 64'd0);

    // Backpressure: 4 beats offered with out_ready low, only 2 fit
    for (int i = 0; i < 4; i++) va[i] = rnd();
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ADD, va[acc_cnt], va[3 - acc_cnt], 1'b0, 1'b0, 1'b0);
      if (last_acc) acc_cnt++;
    end
    chk("bp_accepted", 64'(acc_cnt), 64'd2);
    for (int i = acc_cnt; i < 4; i++) send(ADD, va[i], va[3 - i], 1'b0, 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rnd(), rnd(),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0);
    end
    drain();

    // Accumulate chain
    acc_stalls = 0;
    send(LOAD, 40'd10, 40'd0, 1'b0, 1'b1);
    send(ACC, 40'd5, 40'd0, 1'b0, 1'b1);
    send(ACC, 40'd7, 40'd0, 1'b1, 1'b1);
    drain();
    chk("acc_result", {24'd0, last_sout}, 64'd23);
    chk("acc_stalled", 64'(acc_stalls > 1), 64'd1);

    // ADD traffic around a stalled ACC; ADD must not disturb acc
    send(LOAD, 40'd100, 40'd0, 1'b0, 1'b1);
    send(ADD, 40'd3, 40'd4, 1'b0, 1'b1);
    send(ACC, 40'd1, 40'd0, 1'b0, 1'b1);
    send(ADD, 40'd9, 40'd9, 1'b1, 1'b1);
    send(ACC, 40'd0, 40'd0, 1'b0, 1'b1);
    drain();
    chk("mixed_acc", {24'd0, last_sout}, 64'd101);

    // Reset with two beats in flight
    send(LOAD, 40'h55, 40'd0, 1'b0, 1'b0);
    send(ADD, 40'd1, 40'd2, 1'b0, 1'b0);
    step(1'b1, ADD, 40'd6, 40'd6, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sout", {24'd0, Sout}, 64'd0);
    for (int i = 0; i < 5; i++) step(1'b0, ADD, '0, '0, 1'b0, 1'b1, 1'b0);
    send(ACC, 40'd0, 40'd0, 1'b0, 1'b1);
    drain();
    chk("rst_acc_zero", {24'd0, last_sout}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
